// File: rtl/montgomery_redc_multilane_if.sv
// Stream bus for montgomery_redc_multilane: input beats (x, tag) and output beats
// (result, tag, range flags), each side with its own valid/ready pair.
interface montgomery_redc_multilane_if #(
  parameter int DATA_LENGTH = 64,
  parameter int LANES       = 4,
  parameter int TAG_W       = 4
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [LANES*DATA_LENGTH-1:0] x_i;
  logic [TAG_W-1:0]             tag_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [LANES*DATA_LENGTH-1:0] result_o;
  logic [TAG_W-1:0]             tag_o;
  logic [LANES-1:0]             range_err_o;

  modport slave (
    input  in_valid_i, x_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, range_err_o
  );

  modport master (
    output in_valid_i, x_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, range_err_o
  );
endinterface

// File: rtl/montgomery_redc_multilane.sv
// Multi-lane Montgomery reduction REDC(x) = x * 2^-m_bl mod m, 3-stage lock-step pipeline.
// Optional per-lane input range check is built when MONT_REDC_RANGE_CHECK_EN is defined.
module montgomery_redc_multilane #(
  parameter int DATA_LENGTH = 64,
  parameter int LANES       = 4,
  parameter int TAG_W       = 4,
  parameter int BL_W        = $clog2(DATA_LENGTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_load_i,
  input  logic [DATA_LENGTH-1:0] cfg_m_i,
  input  logic [BL_W-1:0]        cfg_m_bl_i,
  input  logic [DATA_LENGTH-1:0] cfg_minv_i,
  output logic                   cfg_valid_o,
  output logic                   cfg_err_o,
  montgomery_redc_multilane_if.slave s
);
  localparam int DW = DATA_LENGTH;
  localparam int WW = 2 * DATA_LENGTH + 1;

  typedef enum logic {UNCFG, CFG} cfg_state_e;
  cfg_state_e state_q, state_d;

  logic [DW-1:0]   m_q, minv_q;
  logic [BL_W-1:0] bl_q;
  logic            err_q;
  logic [DW-1:0]   mask;
  logic            en, accept, empty, load_ok, load_bad;
  logic            v1_q, v2_q, v3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [LANES-1:0][DW-1:0] res_lanes;

  // A shift of the full width clears every bit, so m_bl = DW yields an all-ones mask.
  assign mask   = ~({DW{1'b1}} << bl_q);
  assign en     = ~v3_q | s.out_ready_i;
  assign s.in_ready_o = en & cfg_valid_o & ~cfg_load_i;
  assign accept = s.in_valid_i & s.in_ready_o;
  assign empty  = ~(v1_q | v2_q | v3_q | accept);

  always_comb begin
    state_d  = state_q;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    if (cfg_load_i) begin
      if (empty && (cfg_m_bl_i != '0)) begin
        load_ok = 1'b1;
        state_d = CFG;
      end else begin
        load_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNCFG;
      m_q     <= '0;
      minv_q  <= '0;
      bl_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | load_bad;
      if (load_ok) begin
        m_q    <= cfg_m_i;
        minv_q <= cfg_minv_i;
        bl_q   <= cfg_m_bl_i;
      end
    end
  end

  assign cfg_valid_o = (state_q == CFG);
  assign cfg_err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else if (en) begin
      v1_q   <= accept;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      tag1_q <= s.tag_i;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
    end
  end

`ifdef MONT_REDC_RANGE_CHECK_EN
  logic [LANES-1:0] rerr_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0] x_lane, q_next, x1_q, q1_q, r_next, r_final, r3_q;
      logic [WW-1:0] t_next, t2_q;

      assign x_lane = s.x_i[gi*DW +: DW];
      assign q_next = DW'((x_lane & mask) * minv_q) & mask;
      assign t_next = (WW'(x1_q) + WW'(q1_q) * WW'(m_q)) >> bl_q;
      assign r_next = (t2_q >= WW'(m_q)) ? DW'(t2_q - WW'(m_q)) : DW'(t2_q);

`ifdef MONT_REDC_RANGE_CHECK_EN
      logic rerr_in, rerr1_q, rerr2_q, rerr3_q;
      assign rerr_in = (WW'(x_lane) >= (WW'(m_q) << bl_q));
      assign r_final = rerr2_q ? '0 : r_next;
      assign rerr_vec[gi] = rerr3_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rerr1_q <= 1'b0;
          rerr2_q <= 1'b0;
          rerr3_q <= 1'b0;
        end else if (en) begin
          rerr1_q <= rerr_in;
          rerr2_q <= rerr1_q;
          rerr3_q <= rerr2_q;
        end
      end
`else
      assign r_final = r_next;
`endif

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          x1_q <= '0;
          q1_q <= '0;
          t2_q <= '0;
          r3_q <= '0;
        end else if (en) begin
          x1_q <= x_lane;
          q1_q <= q_next;
          t2_q <= t_next;
          r3_q <= r_final;
        end
      end

      assign res_lanes[gi] = r3_q;
    end
  endgenerate

  assign s.out_valid_o = v3_q;
  assign s.tag_o       = tag3_q;
  assign s.result_o    = res_lanes;
`ifdef MONT_REDC_RANGE_CHECK_EN
  assign s.range_err_o = rerr_vec;
`else
  assign s.range_err_o = '0;
`endif
endmodule

// File: tb/tb_montgomery_redc_multilane.sv
// Scoreboard bench for montgomery_redc_multilane: directed beats with hand-derived
// REDC results, a negedge monitor checking order, stability under stall and flags.
module tb_montgomery_redc_multilane;
  localparam int DW  = 64;
  localparam int L   = 4;
  localparam int TW  = 4;
  localparam int BLW = $clog2(DW) + 1;
  localparam int VW  = L * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_load = 1'b0;
  logic [DW-1:0]  cfg_m = '0;
  logic [BLW-1:0] cfg_bl = '0;
  logic [DW-1:0]  cfg_minv = '0;
  logic cfg_valid, cfg_err;
  logic rdy = 1'b1;
  logic pat = 1'b1;
  logic toggle_en = 1'b0;
  int   tcnt = 0;

  always #5 clk = ~clk;

  montgomery_redc_multilane_if #(.DATA_LENGTH(DW), .LANES(L), .TAG_W(TW)) bus ();

  montgomery_redc_multilane #(.DATA_LENGTH(DW), .LANES(L), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_load_i(cfg_load), .cfg_m_i(cfg_m),
    .cfg_m_bl_i(cfg_bl), .cfg_minv_i(cfg_minv), .cfg_valid_o(cfg_valid),
    .cfg_err_o(cfg_err), .s(bus)
  );

  assign bus.out_ready_i = toggle_en ? pat : rdy;

  typedef struct packed {
    logic [VW-1:0] res;
    logic [TW-1:0] tag;
    logic [L-1:0]  rerr;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [VW-1:0] lanes(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // ready pattern 1,0,0 repeating, advanced just after each rising edge
  always @(posedge clk) begin
    #1;
    pat = ((tcnt % 3) == 0);
    tcnt++;
  end

  logic          held_v = 1'b0;
  logic [VW-1:0] held_res;
  logic [TW-1:0] held_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid_o) begin
      if (held_v) begin
        check("stall_result_stable", bus.result_o, held_res);
        check("stall_tag_stable", VW'(bus.tag_o), VW'(held_tag));
      end
      if (bus.out_ready_i) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", VW'(1), VW'(0));
        end else begin
          e = sb.pop_front();
          $display("beat tag=%0d result=%0h range_err=%b", bus.tag_o, bus.result_o, bus.range_err_o);
          check("result", bus.result_o, e.res);
          check("tag", VW'(bus.tag_o), VW'(e.tag));
          check("range_err", VW'(bus.range_err_o), VW'(e.rerr));
        end
      end else begin
        held_v   = 1'b1;
        held_res = bus.result_o;
        held_tag = bus.tag_o;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send(input logic [VW-1:0] xv, input logic [TW-1:0] tg,
                      input logic [VW-1:0] rv, input logic [L-1:0] re, output int waits);
    bit done = 1'b0;
    exp_t e;
    waits = 0;
    bus.in_valid_i = 1'b1;
    bus.x_i = xv;
    bus.tag_i = tg;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        e.res = rv; e.tag = tg; e.rerr = re;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    if (!done) check("send_timeout", VW'(0), VW'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", VW'(sb.size()), VW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] m, input logic [BLW-1:0] bl, input logic [DW-1:0] minv);
    cfg_load = 1'b1; cfg_m = m; cfg_bl = bl; cfg_minv = minv;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, wsum;
    logic [DW-1:0] xd;
    bus.in_valid_i = 1'b0;
    bus.x_i = '0;
    bus.tag_i = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", VW'(bus.out_valid_o), VW'(0));
    check("rst_result", bus.result_o, VW'(0));
    check("rst_tag", VW'(bus.tag_o), VW'(0));
    check("rst_cfg_valid", VW'(cfg_valid), VW'(0));
    check("rst_cfg_err", VW'(cfg_err), VW'(0));
    check("rst_in_ready", VW'(bus.in_ready_o), VW'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // m_bl = 0 is rejected
    load(64'd17, '0, 64'd15);
    check("bl0_cfg_err", VW'(cfg_err), VW'(1));
    check("bl0_cfg_valid", VW'(cfg_valid), VW'(0));
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    check("reset_clears_err", VW'(cfg_err), VW'(0));

    load(64'd17, BLW'(5), 64'd15);
    check("load17_cfg_valid", VW'(cfg_valid), VW'(1));
    check("load17_cfg_err", VW'(cfg_err), VW'(0));

    // single beat with latency check
    send(lanes(160, 1, 543, 0), 4'd3, lanes(5, 8, 9, 0), 4'b0, w);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("latency_c%0d", c), VW'(bus.out_valid_o), VW'(c == 3));
    end
    drain();

    // t lands exactly on m for lanes 0..2
    send(lanes(17, 34, 527, 5), 4'd5, lanes(0, 0, 0, 6), 4'b0, w);
    drain();

    // 16 back-to-back beats under a 1,0,0 ready pattern
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++)
      send(lanes(DW'(32*i), DW'(32*i+1), DW'(32*(16-i)), DW'(17*(i+1))), TW'(i),
           lanes(DW'(i), DW'((i+8)%17), DW'(16-i), 0), 4'b0, w);
    toggle_en = 1'b0;
    drain();

    // full throughput with ready held high
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(lanes(DW'(32*i), DW'(32*i+1), DW'(32*(16-i)), DW'(17*(i+1))), TW'(i),
           lanes(DW'(i), DW'((i+8)%17), DW'(16-i), 0), 4'b0, w);
      wsum += w;
    end
    check("throughput_waits", VW'(wsum), VW'(0));
    drain();

    // load and input in the same cycle: load wins
    bus.in_valid_i = 1'b1;
    bus.x_i = lanes(1, 2, 3, 4);
    cfg_load = 1'b1; cfg_m = 64'd8380417; cfg_bl = BLW'(23); cfg_minv = 64'd8380415;
    @(negedge clk);
    check("load_blocks_in_ready", VW'(bus.in_ready_o), VW'(0));
    @(posedge clk); #1;
    cfg_load = 1'b0;
    bus.in_valid_i = 1'b0;
    check("dil_cfg_valid", VW'(cfg_valid), VW'(1));
    check("dil_cfg_err", VW'(cfg_err), VW'(0));

    xd = 64'd8380417 * 64'd8388608 - 64'd1;
    send(lanes(xd, xd, xd, xd), 4'd9, lanes(8185, 8185, 8185, 8185), 4'b0, w);
    drain();

    // load while a beat is in flight is rejected and sticky
    load(64'd17, BLW'(5), 64'd15);
    send(lanes(160, 1, 543, 0), 4'd1, lanes(5, 8, 9, 0), 4'b0, w);
    load(64'd8380417, BLW'(23), 64'd8380415);
    check("busy_load_err", VW'(cfg_err), VW'(1));
    send(lanes(17, 34, 527, 5), 4'd2, lanes(0, 0, 0, 6), 4'b0, w);
    drain();
    check("err_sticky", VW'(cfg_err), VW'(1));

`ifdef MONT_REDC_RANGE_CHECK_EN
    send(lanes(544, 543, 1000, 0), 4'd7, lanes(0, 9, 0, 0), 4'b0101, w);
`else
    send(lanes(544, 543, 1000, 0), 4'd7, lanes(0, 9, 27, 0), 4'b0000, w);
`endif
    drain();

    // reset with beats stuck in a stalled pipeline
    rdy = 1'b0;
    send(lanes(1, 2, 3, 4), 4'd4, lanes(8, 0, 0, 0), 4'b0, w);
    send(lanes(5, 6, 7, 8), 4'd6, lanes(0, 0, 0, 0), 4'b0, w);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", VW'(bus.out_valid_o), VW'(0));
    check("midrst_cfg_valid", VW'(cfg_valid), VW'(0));
    check("midrst_cfg_err", VW'(cfg_err), VW'(0));
    sb.delete();
    rdy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", VW'(bus.out_valid_o), VW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/montgomery_redc_multilane.md
Name: montgomery_redc_multilane

Overview:
- Parametrised successor to the single-lane Montgomery pipeline.
- Computes REDC(x) = x·2^(-m_bl) mod m on LANES independent lanes in lock-step.
- Uses a 3-stage pipeline with valid/ready backpressure, tag passthrough and run-time loadable modulus configuration.
- Sits between the NTT/pointwise-multiply datapath and the coefficient buffers; it serves Dilithium, Kyber or custom moduli without re-synthesis.

Parameters:
- DATA_LENGTH, 64, width of each lane's x input and of m/minv; requires m_bl ≤ DATA_LENGTH/2.
- LANES, 4, number of parallel reduction lanes sharing one handshake.
- TAG_W, 4, width of sideband tag carried with each beat.
- BL_W, $clog2(DATA_LENGTH)+1, width of the modulus bit-length field.

Ports:
- clk_i, in, 1, rising-edge clock.
- rst_ni, in, 1, asynchronous active-low reset.
- cfg_load_i, in, 1, request to latch a new modulus configuration.
- cfg_m_i, in, DATA_LENGTH, modulus m (odd).
- cfg_m_bl_i, in, BL_W, modulus bit length; R = 2^m_bl.
- cfg_minv_i, in, DATA_LENGTH, −m^(−1) mod R.
- cfg_valid_o, out, 1, configuration loaded.
- cfg_err_o, out, 1, sticky: load attempted while the pipeline is non-empty.
- in_valid_i, in, 1, input beat valid.
- in_ready_o, out, 1, input beat accepted when valid & ready.
- x_i, in, LANES×DATA_LENGTH, lane operands, lane 0 in the LSBs.
- tag_i, in, TAG_W, sideband tag.
- out_valid_o, out, 1, result beat valid.
- out_ready_i, in, 1, downstream ready.
- result_o, out, LANES×DATA_LENGTH, REDC results, zero-extended.
- tag_o, out, TAG_W, tag aligned with result_o.
- range_err_o, out, LANES, per-lane out-of-range flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; all stage valids cleared; configuration registers 0.
- Reset mid-operation discards all in-flight beats.
- Arithmetic per lane, with R = 2^m_bl and masks derived from the latched m_bl:
  - S1: q = ((x mod R)·minv) mod R.
  - S2: t = (x + q·m) >> m_bl.
  - S3: r = (t ≥ m) ? t − m : t.
- Valid input range is x < m·R; results are then in [0, m).
- Intermediate width is 2·DATA_LENGTH+1, so no overflow is possible.
- Latency: 3 cycles from accept to out_valid_o when unstalled. Throughput is 1 beat/cycle. Ordering is strict in-order.
- Stall rule: global enable en = ~out_valid_o | out_ready_i. When en=0, all stage registers hold.
- in_ready_o = en & cfg_valid_o & ~cfg_load_i.
- Handshake:
  - out_valid_o, result_o and tag_o stay stable while out_valid_o=1 and out_ready_i=0.
  - in_valid_i may drop without having been accepted.
- Configuration FSM:
  - States: UNCFG → (cfg_load_i & empty) → CFG; CFG → (cfg_load_i & empty) → CFG with new values.
  - empty means no stage valid and no beat accepted this cycle.
  - cfg_load_i while non-empty: load ignored, cfg_err_o set; cleared only by reset.
  - cfg_valid_o rises the cycle after a successful load.
  - Config registers feed all stages. Changing them with beats in flight is impossible by construction.
- Boundary cases:
  - x=0 → r=0.
  - t exactly equal to m → r=0.
  - cfg_load_i and in_valid_i in the same cycle: in_ready_o=0, so the load wins if the pipeline is empty.
  - m_bl=0 is illegal; the load is ignored and cfg_err_o is set.

Optional Feature:
- Macro: MONT_REDC_RANGE_CHECK_EN.
- Enabled:
  - S1 compares each lane's x against m<<m_bl.
  - If x ≥ m·R, the lane's range_err_o bit travels with the beat and asserts with out_valid_o, and that lane's result_o is forced to 0.
- Disabled: no comparator is built; range_err_o is tied to 0.

Test Plan:
- Reset, then load m=17, m_bl=5, minv=15 → cfg_valid_o=1 next cycle, cfg_err_o=0.
- One beat, lanes x={160, 1, 543, 0}, tag=3 → 3 cycles later result={5, 8, 9, 0}, tag_o=3.
- 16 back-to-back beats with out_ready_i toggling 1,0,0,1,… → every beat delivered once, in order, stable during stall; 1 beat/cycle when ready is held high.
- Dilithium: load m=8380417, m_bl=23, minv=8380415; send x=8380417·2^23−1 on all lanes → all results equal x·2^(−23) mod m per the software model; no range_err.
- cfg_load_i issued one cycle after a beat is accepted → load ignored, cfg_err_o=1 sticky, old modulus still used for that and later beats; rst_ni low mid-stream → out_valid_o=0, cfg_valid_o=0 immediately.
- With MONT_REDC_RANGE_CHECK_EN and m=17, m_bl=5: x={544, 543, 1000, 0} → range_err_o=4'b0101, result={0, 9, 0, 0}.
